// File: rtl/delay_sched_if.sv
// Handshake bundle between requesting control FSMs and the shared delay scheduler.
interface delay_sched_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0] req;
  logic [DW-1:0]    delay_len;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic             busy;
  logic             tick;

  modport master (output req, delay_len, input grant, done, busy, tick);
  modport slave  (input req, delay_len, output grant, done, busy, tick);
endinterface

// File: rtl/delay_sched.sv
// Round-robin shared delay timer: one delay of delay_len x 2^PRESC_W clk cycles in flight.
// Optional DELAY_SCHED_ABORT_EN: owner dropping req during COUNT cancels its delay.
module delay_sched #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int PRESC_W = 6
) (
  input logic         clk,
  input logic         rstn,
  delay_sched_if.slave bus
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t             state, state_n;
  logic [PRESC_W-1:0] presc, presc_n;
  logic [DW-1:0]      rem, rem_n;
  logic [N_REQ-1:0]   grant, grant_n;
  logic [N_REQ-1:0]   done, done_n;
  logic [IW-1:0]      owner, owner_n;
  logic [IW-1:0]      rr_ptr, rr_n;
  logic [IW-1:0]      win_idx, nxt_owner;
  logic               win_found;
  logic [IW:0]        cand;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!win_found && bus.req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  assign nxt_owner = (owner == IW'(N_REQ-1)) ? '0 : owner + IW'(1);

  always_comb begin
    state_n = state;
    presc_n = presc;
    rem_n   = rem;
    grant_n = grant;
    done_n  = '0;
    owner_n = owner;
    rr_n    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_n          = COUNT;
          grant_n          = '0;
          grant_n[win_idx] = 1'b1;
          owner_n          = win_idx;
          rem_n            = bus.delay_len;
          presc_n          = '0;
        end
      end
      COUNT: begin
`ifdef DELAY_SCHED_ABORT_EN
        if (!bus.req[owner]) begin
          state_n = IDLE;
          grant_n = '0;
          rr_n    = nxt_owner;
        end else
`endif
        if (rem == '0) begin
          state_n = DONE;
          done_n  = grant;
        end else begin
          presc_n = presc + PRESC_W'(1);
          if (&presc) begin
            rem_n = rem - DW'(1);
            if (rem == DW'(1)) begin
              state_n = DONE;
              done_n  = grant;
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
        rr_n    = nxt_owner;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      presc  <= '0;
      rem    <= '0;
      grant  <= '0;
      done   <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      rem    <= rem_n;
      grant  <= grant_n;
      done   <= done_n;
      owner  <= owner_n;
      rr_ptr <= rr_n;
    end
  end

  assign bus.grant = grant;
  assign bus.done  = done;
  assign bus.busy  = (state != IDLE);
  assign bus.tick  = (state == COUNT) && (&presc);
endmodule
